// File: rtl/core_mem_responder_pkg.sv
// Shared constants for the core data-memory responder: request encodings,
// default field widths and the per-core handshake state encodings.
package core_mem_responder_pkg;

  localparam int ENABLE_SIZE = 2;

  localparam logic [ENABLE_SIZE-1:0] ENABLE_NONE    = 2'b00;
  localparam logic [ENABLE_SIZE-1:0] ENABLE_READ    = 2'b01;
  localparam logic [ENABLE_SIZE-1:0] ENABLE_WRITE   = 2'b10;
  localparam logic [ENABLE_SIZE-1:0] ENABLE_ILLEGAL = 2'b11;

  localparam int REG_SIZE     = 8;
  localparam int CORE_ID_SIZE = 4;
  localparam int ADDR_SIZE    = CORE_ID_SIZE + REG_SIZE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef logic [ENABLE_SIZE-1:0] enable_t;

  // Only READ and WRITE touch a bank; NONE and the illegal code never do.
  function automatic logic is_access(input enable_t en);
    return (en == ENABLE_READ) || (en == ENABLE_WRITE);
  endfunction

endpackage

// File: rtl/core_mem_responder_rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant, priority searched upward
// from a registered pointer that moves just past the last winner.
module rr_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] grant
);

  localparam int PW = $clog2(NUM_CORES);

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] idx;
  logic          found;

  // NUM_CORES is a power of two, so PW-bit addition wraps modulo NUM_CORES.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = ptr + PW'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = idx + 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/core_mem_responder.sv
// Banked data-memory responder: one SRAM bank and one round-robin arbiter per
// core, with a per-core IDLE/WAIT/RESP handshake producing a one-cycle ready.
module core_mem_responder #(
  parameter int NUM_CORES    = 4,
  parameter int REG_SIZE     = 8,
  parameter int CORE_ID_SIZE = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [2*NUM_CORES-1:0]                   enable_M,
  input  logic [(CORE_ID_SIZE+REG_SIZE)*NUM_CORES-1:0] addr_M,
  input  logic [REG_SIZE*NUM_CORES-1:0]            wr_data_M,
  output logic [REG_SIZE*NUM_CORES-1:0]            rd_data_M,
  output logic [NUM_CORES-1:0]                     ready_M
);

  import core_mem_responder_pkg::ENABLE_SIZE;
  import core_mem_responder_pkg::ENABLE_NONE;
  import core_mem_responder_pkg::ENABLE_READ;
  import core_mem_responder_pkg::ENABLE_WRITE;
  import core_mem_responder_pkg::ST_IDLE;
  import core_mem_responder_pkg::ST_WAIT;
  import core_mem_responder_pkg::ST_RESP;
  import core_mem_responder_pkg::is_access;

  localparam int ADDR_SIZE = CORE_ID_SIZE + REG_SIZE;
  localparam int DEPTH     = 2 ** REG_SIZE;
  localparam int BW        = $clog2(NUM_CORES);

  logic [ENABLE_SIZE-1:0]  en        [NUM_CORES];
  logic [CORE_ID_SIZE-1:0] bank_id   [NUM_CORES];
  logic [REG_SIZE-1:0]     offset    [NUM_CORES];
  logic [REG_SIZE-1:0]     wdata     [NUM_CORES];
  logic [REG_SIZE-1:0]     core_rdata[NUM_CORES];
  logic [1:0]              st        [NUM_CORES];
  logic [REG_SIZE-1:0]     rd_data_p0[NUM_CORES];

  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] in_range;
  logic [NUM_CORES-1:0] bypass;
  logic [NUM_CORES-1:0] granted;

  logic [NUM_CORES-1:0] bank_req  [NUM_CORES];
  logic [NUM_CORES-1:0] bank_grant[NUM_CORES];
  logic [NUM_CORES-1:0] bank_we;
  logic [REG_SIZE-1:0]  bank_off  [NUM_CORES];
  logic [REG_SIZE-1:0]  bank_wdata[NUM_CORES];
  logic [REG_SIZE-1:0]  bank_rdata[NUM_CORES];

  // Request decode: a core in RESP is blind to the still-held old request.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      en[c]       = enable_M[2*c +: 2];
      offset[c]   = addr_M[c*ADDR_SIZE +: REG_SIZE];
      bank_id[c]  = addr_M[c*ADDR_SIZE+REG_SIZE +: CORE_ID_SIZE];
      wdata[c]    = wr_data_M[c*REG_SIZE +: REG_SIZE];
      eligible[c] = (st[c] != ST_RESP) && (en[c] != ENABLE_NONE);
      in_range[c] = is_access(en[c]) && (int'(bank_id[c]) < NUM_CORES);
      bypass[c]   = eligible[c] && !in_range[c];
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_CORES; b++) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        bank_req[b][c] = eligible[c] && in_range[c] && (int'(bank_id[c]) == b);
      end
    end
  end

  // Each bank grants at most one core per cycle, so its port is a simple mux.
  always_comb begin
    for (int b = 0; b < NUM_CORES; b++) begin
      bank_we[b]    = 1'b0;
      bank_off[b]   = '0;
      bank_wdata[b] = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (bank_grant[b][c]) begin
          bank_we[b]    = (en[c] == ENABLE_WRITE);
          bank_off[b]   = offset[c];
          bank_wdata[b] = wdata[c];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      granted[c] = bypass[c];
      for (int b = 0; b < NUM_CORES; b++) begin
        granted[c] = granted[c] | bank_grant[b][c];
      end
      core_rdata[c] = (in_range[c] && (en[c] == ENABLE_READ))
                    ? bank_rdata[bank_id[c][BW-1:0]] : '0;
    end
  end

  for (genvar b = 0; b < NUM_CORES; b++) begin : g_bank
    logic [REG_SIZE-1:0] mem [DEPTH];

    rr_arbiter #(
      .NUM_CORES(NUM_CORES)
    ) u_arb (
      .clk  (clk),
      .reset(reset),
      .req  (bank_req[b]),
      .grant(bank_grant[b])
    );

    // Contents survive reset; writes are merely suppressed while it is held.
    always_ff @(posedge clk) begin
      if (bank_we[b] && !reset) begin
        mem[bank_off[b]] <= bank_wdata[b];
      end
    end

    assign bank_rdata[b] = mem[bank_off[b]];
  end

  // Grant edge: state moves to RESP and the response word is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        st[c]         <= ST_IDLE;
        rd_data_p0[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        case (st[c])
          ST_RESP: st[c] <= ST_IDLE;
          ST_IDLE: begin
            if (granted[c]) begin
              st[c] <= ST_RESP;
            end else if (en[c] != ENABLE_NONE) begin
              st[c] <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (granted[c]) begin
              st[c] <= ST_RESP;
            end
          end
          default: st[c] <= ST_IDLE;
        endcase
        if (granted[c]) begin
          rd_data_p0[c] <= core_rdata[c];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      ready_M[c]                      = (st[c] == ST_RESP);
      rd_data_M[c*REG_SIZE +: REG_SIZE] = rd_data_p0[c];
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder with four cores: handshake latency,
// arbitration order, bank isolation, bypass requests and asynchronous reset.
module tb_core_mem_responder;

  localparam int NC = 4;
  localparam int RS = 8;
  localparam int CS = 4;
  localparam int AS = CS + RS;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;
  localparam logic [1:0] ILL   = 2'b11;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [2*NC-1:0]  enable_M;
  logic [AS*NC-1:0] addr_M;
  logic [RS*NC-1:0] wr_data_M;
  logic [RS*NC-1:0] rd_data_M;
  logic [NC-1:0]    ready_M;

  logic [1:0]    en_v [NC];
  logic [AS-1:0] ad_v [NC];
  logic [RS-1:0] wd_v [NC];

  int checks = 0;
  int fails  = 0;

  core_mem_responder #(
    .NUM_CORES   (NC),
    .REG_SIZE    (RS),
    .CORE_ID_SIZE(CS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable_M (enable_M),
    .addr_M   (addr_M),
    .wr_data_M(wr_data_M),
    .rd_data_M(rd_data_M),
    .ready_M  (ready_M)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      enable_M[2*c +: 2]   = en_v[c];
      addr_M[c*AS +: AS]   = ad_v[c];
      wr_data_M[c*RS +: RS] = wd_v[c];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int c, input logic [1:0] e, input logic [AS-1:0] a,
                     input logic [RS-1:0] d);
    en_v[c] = e;
    ad_v[c] = a;
    wd_v[c] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RS-1:0] rd(input int c);
    return rd_data_M[c*RS +: RS];
  endfunction

  initial begin
    for (int c = 0; c < NC; c++) req(c, NONE, '0, '0);

    // Reset state
    step();
    step();
    chk("reset_ready", 32'(ready_M), 32'h0);
    chk("reset_rd", 32'(rd_data_M), 32'h0);
    reset = 1'b0;

    // Core0 write then back-to-back read of {bank1, 0x10}; read held in RESP is ignored
    req(0, WRITE, 12'h110, 8'h5A);
    step();
    chk("wr_ready", 32'(ready_M), 32'h1);
    chk("wr_rd_zero", 32'(rd(0)), 32'h0);
    req(0, READ, 12'h110, 8'h00);
    step();
    chk("resp_to_idle", 32'(ready_M), 32'h0);
    step();
    chk("rd_ready", 32'(ready_M), 32'h1);
    chk("rd_data_5a", 32'(rd(0)), 32'h5A);
    step();
    chk("held_no_regrant", 32'(ready_M), 32'h0);
    req(0, NONE, '0, '0);
    step();
    chk("idle_quiet", 32'(ready_M), 32'h0);

    // Seed bank2, then three cores contend for it
    req(3, WRITE, 12'h220, 8'h77);
    step();
    chk("seed_b2_ready", 32'(ready_M), 32'h8);
    req(3, NONE, '0, '0);
    step();
    req(0, READ, 12'h220, '0);
    req(1, READ, 12'h220, '0);
    req(2, READ, 12'h220, '0);
    step();
    chk("rr_first", 32'(ready_M), 32'h1);
    chk("rr_first_data", 32'(rd(0)), 32'h77);
    req(0, NONE, '0, '0);
    step();
    chk("rr_second", 32'(ready_M), 32'h2);
    chk("rr_second_data", 32'(rd(1)), 32'h77);
    req(1, NONE, '0, '0);
    step();
    chk("rr_third", 32'(ready_M), 32'h4);
    chk("rr_third_data", 32'(rd(2)), 32'h77);
    req(2, NONE, '0, '0);
    step();
    chk("rr_done", 32'(ready_M), 32'h0);

    // Different banks in parallel: core3 reads bank0 while core1 writes bank3
    req(3, WRITE, 12'h005, 8'hC3);
    step();
    req(3, NONE, '0, '0);
    step();
    req(3, READ, 12'h005, '0);
    req(1, WRITE, 12'h333, 8'h99);
    step();
    chk("parallel_ready", 32'(ready_M), 32'hA);
    chk("parallel_rd3", 32'(rd(3)), 32'hC3);
    chk("parallel_rd1", 32'(rd(1)), 32'h0);
    req(3, NONE, '0, '0);
    req(1, NONE, '0, '0);
    step();
    req(2, READ, 12'h333, '0);
    step();
    chk("b3_readback", 32'(rd(2)), 32'h99);
    req(2, NONE, '0, '0);
    step();

    // Out-of-range bank and illegal enable are answered at once with zero
    req(0, READ, 12'hF10, '0);
    step();
    chk("oor_ready", 32'(ready_M), 32'h1);
    chk("oor_rd", 32'(rd(0)), 32'h0);
    req(0, NONE, '0, '0);
    step();
    req(0, ILL, 12'h110, 8'hFF);
    step();
    chk("ill_ready", 32'(ready_M), 32'h1);
    chk("ill_rd", 32'(rd(0)), 32'h0);
    req(0, NONE, '0, '0);
    step();
    req(0, READ, 12'h110, '0);
    step();
    chk("ill_no_write", 32'(rd(0)), 32'h5A);
    req(0, NONE, '0, '0);
    step();

    // Core2 waits behind core1; reset hits mid-operation
    req(1, READ, 12'h110, '0);
    req(2, READ, 12'h110, '0);
    step();
    chk("pre_reset_ready", 32'(ready_M), 32'h2);
    chk("pre_reset_rd1", 32'(rd(1)), 32'h5A);
    reset = 1'b1;
    #1;
    chk("async_ready", 32'(ready_M), 32'h0);
    chk("async_rd", 32'(rd_data_M), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req(1, NONE, '0, '0);
    req(0, READ, 12'h110, '0);
    step();
    chk("post_reset_ptr0", 32'(ready_M), 32'h1);
    chk("post_reset_data", 32'(rd(0)), 32'h5A);
    req(0, NONE, '0, '0);
    step();
    chk("post_reset_core2", 32'(ready_M), 32'h4);
    chk("post_reset_rd2", 32'(rd(2)), 32'h5A);
    req(2, NONE, '0, '0);
    step();
    chk("final_idle", 32'(ready_M), 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
